dump_timer_mc: RTL and testbench
================================

# dump_timer_mc

Multi-channel, parametrised successor to the single-channel dump timer used by the NMR sequencer. Each channel counts `clk_sys` cycles while the global `state_start` and its own `timer_start` bit are both high. Each channel compares against a programmable terminal count and flags expiry in one-shot or periodic mode. Channel outputs feed the dump/echo sequencing logic as duration timers and elapsed-time monitors.

## Interface
- `NCH`, default 4: number of independent channels, 1..16.
- `WIDTH`, default 12: counter width per channel, 4..32.

- `clk_sys`  in  1: system clock; all logic rises on it.
- `rst`  in  1: synchronous, active-high reset.
- `state_start`  in  1: global sequencer enable, common to all channels.
- `timer_start`  in  NCH: per-channel start.
- `tc`  in  NCH*WIDTH: per-channel terminal count; channel i occupies bits [i*WIDTH +: WIDTH].
- `mode`  in  NCH: per-channel mode; 0 = ONESHOT, 1 = PERIODIC.
- `count`  out  NCH*WIDTH: per-channel counter value, same packing as `tc`.
- `done`  out  NCH: one-cycle terminal pulse per channel.
- `expired`  out  NCH: sticky expiry flag per channel.
- `snap`  out  NCH*WIDTH: elapsed count captured at disable.
- `snap_vld`  out  NCH: one-cycle pulse marking a new `snap`.

## Operation
Each channel i is evaluated independently every cycle.
- Enable: `en[i]` = `state_start & timer_start[i]`.
- `rst` high: every output is cleared to 0 (`count`, `done`, `expired`, `snap`, `snap_vld`, internal `en_d`). Reset takes priority mid-count.
- `en[i]` low: `count` = 0, `expired` = 0, `done` = 0.
- `en[i]` high and `count < tc`: `count` increments by 1; `done` = 0.
- `en[i]` high and `count >= tc` (terminal):
  - ONESHOT: `count` holds. `done` = 1 only when `expired` was 0; `expired` <= 1.
  - PERIODIC: `count` <= 0, `done` = 1, `expired` <= 1.
- The terminal test is `>=`, which gives these boundary behaviours:
  - Lowering `tc` below the running count terminates on the next cycle.
  - `count` never wraps past all-ones.
- `tc = 0`:
  - ONESHOT: `done` on the first enabled edge; `count` stays 0.
  - PERIODIC: `done` high on every enabled cycle.
- `mode` and `tc` are sampled live each cycle. Changing `mode` mid-run takes effect on the next terminal evaluation.

## Timing
- Single cycle, no pipelining; every output is registered.
- `en[i]` first seen high at edge k: `count` = 1 after edge k.
- For `tc = N`, `count` first reads N after edge k+N-1, and `done` / `expired` rise after edge k+N.
- PERIODIC period: N+1 cycles. `done` is high in the same cycle `count` reads 0 after the terminal.
- Deasserting `en[i]` at edge j: `count` = 0 and `expired` = 0 after edge j. A `done` that would have fired at edge j is suppressed.
- Channels never interact. Simultaneous terminals on several channels assert their `done` bits in the same cycle.

## Configuration
- Macro: `DUMP_TIMER_SNAPSHOT_EN`.
- Defined: each channel keeps `en_d`.
  - On `en_d & ~en[i]` (falling enable), `snap[i]` <= the pre-clear `count[i]` and `snap_vld[i]` pulses for one cycle.
  - `snap` holds its value until the next falling enable or `rst`.
- Undefined: `snap` and `snap_vld` are tied to constant 0, and no snapshot registers are inferred. The port list is identical in both builds.

## Structure
- Package `dump_timer_pkg` holds:
  - mode constants `MODE_ONESHOT = 1'b0` and `MODE_PERIODIC = 1'b1`;
  - parameter limit constants `NCH_MAX = 16` and `WIDTH_MAX = 32`.
- Sub-module `dump_timer_chan`: one channel (counter, compare, `done` / `expired`, optional snapshot).
- The top level is a generate loop over `NCH` instances plus the shared `state_start` AND-ing and the port packing.

## Test plan
1. **Reset mid-count.** `NCH=4`, `WIDTH=12`; run channel 0 to `count = 5`, then pulse `rst` for 1 cycle -> all outputs read 0 on the next cycle; the count restarts at 1 one cycle after `rst` falls with enables still high.
2. **One-shot expiry.** ch0 ONESHOT, `tc = 10`, enable held for 20 cycles -> `count` 1..10 then holds 10; `done` high exactly once, at the 11th enabled edge; `expired` stays 1 until disable.
3. **Periodic with zero terminal.** ch1 PERIODIC, `tc = 3` -> `count` sequence 1,2,3,0,1,2,3,0; `done` high whenever `count` reads 0 after a terminal, i.e. every 4 cycles. Then set `tc = 0` -> `done` held high and `count` stuck at 0.
4. **Global gating and independence.** Drop `state_start` for 1 cycle while ch0..ch3 run with different `tc` -> all counts and `expired` flags clear; every channel restarts from 1. Verify channels do not interact when their terminals coincide.
5. **Live `tc` lowering.** ch2 ONESHOT at `count = 50`, write `tc = 20` -> `done` fires on the next edge and `count` holds 50.
6. **Snapshot build.** With `DUMP_TIMER_SNAPSHOT_EN` defined, disable ch3 at `count = 37` -> `snap` reads 37 with a single `snap_vld` pulse, and `count` reads 0. Without the macro -> `snap` and `snap_vld` stay 0 throughout.

Source files
------------

// File: rtl/dump_timer_pkg.sv
// Shared constants for the multi-channel dump timer.
// Optional snapshot feature: define DUMP_TIMER_SNAPSHOT_EN.
package dump_timer_pkg;

  localparam int unsigned NCH_MAX   = 16;
  localparam int unsigned WIDTH_MAX = 32;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/dump_timer_mc_if.sv
// Sequencer-side bus of the multi-channel dump timer.
// Optional snapshot feature: define DUMP_TIMER_SNAPSHOT_EN (signals exist in both builds).
interface dump_timer_mc_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 12
);

  logic                   state_start;
  logic [NCH-1:0]         timer_start;
  logic [NCH*WIDTH-1:0]   tc;
  logic [NCH-1:0]         mode;
  logic [NCH*WIDTH-1:0]   count;
  logic [NCH-1:0]         done;
  logic [NCH-1:0]         expired;
  logic [NCH*WIDTH-1:0]   snap;
  logic [NCH-1:0]         snap_vld;

  modport master (
    output state_start, timer_start, tc, mode,
    input  count, done, expired, snap, snap_vld
  );

  modport slave (
    input  state_start, timer_start, tc, mode,
    output count, done, expired, snap, snap_vld
  );

endinterface

// File: rtl/dump_timer_chan.sv
// One dump-timer channel: counter, terminal compare, done/expired flags.
// Optional snapshot of the elapsed count on falling enable: define DUMP_TIMER_SNAPSHOT_EN.
module dump_timer_chan
  import dump_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_tc,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_done,
  output logic             o_expired,
  output logic [WIDTH-1:0] o_snap,
  output logic             o_snap_vld
);

  logic [WIDTH-1:0] r_count;
  logic             r_done;
  logic             r_expired;

  // Count while enabled; terminal test is >= so a lowered tc ends the run at once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else if (!i_en) begin
      r_count   <= '0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else if (r_count < i_tc) begin
      r_count <= r_count + WIDTH'(1);
      r_done  <= 1'b0;
    end else if (i_mode == MODE_PERIODIC) begin
      r_count   <= '0;
      r_done    <= 1'b1;
      r_expired <= 1'b1;
    end else begin
      r_done    <= ~r_expired;
      r_expired <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_done    = r_done;
  assign o_expired = r_expired;

`ifdef DUMP_TIMER_SNAPSHOT_EN
  logic             r_en_d;
  logic [WIDTH-1:0] r_snap;
  logic             r_snap_vld;

  // Capture the pre-clear count on the falling edge of the enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en_d     <= 1'b0;
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
    end else begin
      r_en_d     <= i_en;
      r_snap_vld <= r_en_d & ~i_en;
      if (r_en_d && !i_en) begin
        r_snap <= r_count;
      end
    end
  end

  assign o_snap     = r_snap;
  assign o_snap_vld = r_snap_vld;
`else
  assign o_snap     = '0;
  assign o_snap_vld = 1'b0;
`endif

endmodule

// File: rtl/dump_timer_mc.sv
// Multi-channel dump timer: NCH independent channels gated by a global start.
// Optional snapshot feature: define DUMP_TIMER_SNAPSHOT_EN.
module dump_timer_mc
  import dump_timer_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic           clk_sys,
  input  logic           rst,
  dump_timer_mc_if.slave bus
);

  logic [NCH-1:0]       w_en;
  logic [NCH*WIDTH-1:0] w_count;
  logic [NCH-1:0]       w_done;
  logic [NCH-1:0]       w_expired;
  logic [NCH*WIDTH-1:0] w_snap;
  logic [NCH-1:0]       w_snap_vld;

  assign w_en = {NCH{bus.state_start}} & bus.timer_start;

  // One channel instance per timer, packed WIDTH bits per channel
  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    dump_timer_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .i_clk      (clk_sys),
      .i_rst      (rst),
      .i_en       (w_en[g]),
      .i_tc       (bus.tc[g*WIDTH +: WIDTH]),
      .i_mode     (bus.mode[g]),
      .o_count    (w_count[g*WIDTH +: WIDTH]),
      .o_done     (w_done[g]),
      .o_expired  (w_expired[g]),
      .o_snap     (w_snap[g*WIDTH +: WIDTH]),
      .o_snap_vld (w_snap_vld[g])
    );
  end

  assign bus.count    = w_count;
  assign bus.done     = w_done;
  assign bus.expired  = w_expired;
  assign bus.snap     = w_snap;
  assign bus.snap_vld = w_snap_vld;

endmodule

// File: tb/tb_dump_timer_mc.sv
// Bench for dump_timer_mc: directed table, corner sequences, random run vs. model.
// Snapshot expectations follow DUMP_TIMER_SNAPSHOT_EN.
module tb_dump_timer_mc;
  import dump_timer_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 12;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  dump_timer_mc_if #(.NCH(NCH), .WIDTH(W)) bus ();

  dump_timer_mc #(.NCH(NCH), .WIDTH(W)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  // stimulus
  logic           ss;
  logic [NCH-1:0] ts;
  logic [NCH-1:0] md;
  int             tcv [NCH];

  assign bus.state_start = ss;
  assign bus.timer_start = ts;
  assign bus.mode        = md;
  always_comb begin
    bus.tc = '0;
    for (int i = 0; i < int'(NCH); i++) bus.tc[i*W +: W] = W'(tcv[i]);
  end

  // reference model state
  int m_cnt [NCH];
  bit m_done [NCH];
  bit m_exp [NCH];
  bit m_en_d [NCH];
  int m_snap [NCH];
  bit m_snapv [NCH];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int i);
    return int'(bus.count[i*W +: W]);
  endfunction

  // Apply the timer rules to the model for one clock edge
  task automatic model_step();
    for (int i = 0; i < int'(NCH); i++) begin
      bit en;
      en = ss & ts[i];
      if (rst) begin
        m_cnt[i] = 0; m_done[i] = 0; m_exp[i] = 0;
        m_en_d[i] = 0; m_snap[i] = 0; m_snapv[i] = 0;
      end else begin
        m_snapv[i] = m_en_d[i] && !en;
        if (m_snapv[i]) m_snap[i] = m_cnt[i];
        m_en_d[i] = en;
        if (!en) begin
          m_cnt[i] = 0; m_done[i] = 0; m_exp[i] = 0;
        end else if (m_cnt[i] < tcv[i]) begin
          m_cnt[i]++; m_done[i] = 0;
        end else if (md[i] == MODE_PERIODIC) begin
          m_cnt[i] = 0; m_done[i] = 1; m_exp[i] = 1;
        end else begin
          m_done[i] = !m_exp[i]; m_exp[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < int'(NCH); i++) begin
      int  es;
      bit  ev;
`ifdef DUMP_TIMER_SNAPSHOT_EN
      es = m_snap[i]; ev = m_snapv[i];
`else
      es = 0; ev = 0;
`endif
      chk($sformatf("ch%0d count", i), 64'(bus.count[i*W +: W]), 64'(m_cnt[i]));
      chk($sformatf("ch%0d done", i), 64'(bus.done[i]), 64'(m_done[i]));
      chk($sformatf("ch%0d expired", i), 64'(bus.expired[i]), 64'(m_exp[i]));
      chk($sformatf("ch%0d snap", i), 64'(bus.snap[i*W +: W]), 64'(es));
      chk($sformatf("ch%0d snap_vld", i), 64'(bus.snap_vld[i]), 64'(ev));
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    bit ss;
    bit ts0;
    int tc0;
    bit md0;
    int e_cnt;
    bit e_done;
    bit e_exp;
  } vec_t;

  vec_t vt [15];

  initial begin
    int dn;

    vt[0]  = '{1, 1, 3, 0, 1, 0, 0};
    vt[1]  = '{1, 1, 3, 0, 2, 0, 0};
    vt[2]  = '{1, 1, 3, 0, 3, 0, 0};
    vt[3]  = '{1, 1, 3, 0, 3, 1, 1};
    vt[4]  = '{1, 1, 3, 0, 3, 0, 1};
    vt[5]  = '{1, 0, 3, 0, 0, 0, 0};
    vt[6]  = '{1, 1, 2, 1, 1, 0, 0};
    vt[7]  = '{1, 1, 2, 1, 2, 0, 0};
    vt[8]  = '{1, 1, 2, 1, 0, 1, 1};
    vt[9]  = '{1, 1, 2, 1, 1, 0, 1};
    vt[10] = '{1, 1, 0, 1, 0, 1, 1};
    vt[11] = '{1, 1, 0, 1, 0, 1, 1};
    vt[12] = '{0, 1, 0, 1, 0, 0, 0};
    vt[13] = '{1, 1, 0, 0, 0, 1, 1};
    vt[14] = '{1, 1, 0, 0, 0, 0, 1};

    rst = 1'b1; ss = 1'b0; ts = '0; md = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      tcv[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_exp[i] = 0;
      m_en_d[i] = 0; m_snap[i] = 0; m_snapv[i] = 0;
    end
    tick();
    tick();
    chk("reset count", 64'(bus.count), 64'(0));
    rst = 1'b0;
    tick();

    // directed table on channel 0
    for (int r = 0; r < 15; r++) begin
      ss = vt[r].ss; ts = {3'b000, vt[r].ts0}; tcv[0] = vt[r].tc0; md[0] = vt[r].md0;
      tick();
      chk($sformatf("tbl%0d count", r), 64'(cnt_of(0)), 64'(vt[r].e_cnt));
      chk($sformatf("tbl%0d done", r), 64'(bus.done[0]), 64'(vt[r].e_done));
      chk($sformatf("tbl%0d expired", r), 64'(bus.expired[0]), 64'(vt[r].e_exp));
    end
    ss = 1'b1; ts = '0; tick();

    // reset mid-count
    tcv[0] = 100; md[0] = MODE_ONESHOT; ts = 4'b0001;
    repeat (5) tick();
    chk("pre-reset count", 64'(cnt_of(0)), 64'(5));
    rst = 1'b1; tick();
    chk("reset all count", 64'(bus.count), 64'(0));
    chk("reset all flags", 64'({bus.done, bus.expired, bus.snap_vld}), 64'(0));
    rst = 1'b0; tick();
    chk("restart count", 64'(cnt_of(0)), 64'(1));
    ts = '0; tick();

    // one-shot expiry, tc=10, 20 enabled edges
    tcv[0] = 10; ts = 4'b0001; dn = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.done[0]) dn++;
      if (c == 11) chk("oneshot done@11", 64'(bus.done[0]), 64'(1));
    end
    chk("oneshot done pulses", 64'(dn), 64'(1));
    chk("oneshot hold", 64'(cnt_of(0)), 64'(10));
    chk("oneshot expired", 64'(bus.expired[0]), 64'(1));
    ts = '0; tick();
    chk("disable clears expired", 64'(bus.expired[0]), 64'(0));

    // live tc lowering on ch2
    tcv[2] = 100; md[2] = MODE_ONESHOT; ts = 4'b0100;
    repeat (50) tick();
    chk("ch2 at 50", 64'(cnt_of(2)), 64'(50));
    tcv[2] = 20; tick();
    chk("ch2 lowered done", 64'(bus.done[2]), 64'(1));
    chk("ch2 lowered hold", 64'(cnt_of(2)), 64'(50));
    ts = '0; tick();

    // global gating with mixed channels
    tcv[0] = 3; tcv[1] = 5; tcv[2] = 7; tcv[3] = 9; md = 4'b0101; ts = 4'b1111;
    repeat (12) tick();
    ss = 1'b0; tick();
    chk("gated counts", 64'(bus.count), 64'(0));
    chk("gated expired", 64'(bus.expired), 64'(0));
    ss = 1'b1; tick();
    for (int i = 0; i < int'(NCH); i++) chk($sformatf("ch%0d restart", i), 64'(cnt_of(i)), 64'(1));
    ts = '0; tick();
    for (int i = 0; i < int'(NCH); i++) tcv[i] = 4;
    ts = 4'b1111;
    repeat (5) tick();
    chk("coincident done", 64'(bus.done), 64'(4'b1111));
    ts = '0; tick();

    // snapshot on ch3 at 37
    tcv[3] = 100; md[3] = MODE_ONESHOT; ts = 4'b1000;
    repeat (37) tick();
    ts = '0; tick();
    chk("snap count cleared", 64'(cnt_of(3)), 64'(0));
`ifdef DUMP_TIMER_SNAPSHOT_EN
    chk("snap value", 64'(bus.snap[3*W +: W]), 64'(37));
    chk("snap_vld pulse", 64'(bus.snap_vld[3]), 64'(1));
    tick();
    chk("snap_vld one cycle", 64'(bus.snap_vld[3]), 64'(0));
    chk("snap holds", 64'(bus.snap[3*W +: W]), 64'(37));
`else
    chk("snap tied", 64'(bus.snap), 64'(0));
    chk("snap_vld tied", 64'(bus.snap_vld), 64'(0));
    tick();
`endif

    // full-width terminal on ch1, periodic
    tcv[1] = 4095; md[1] = MODE_PERIODIC; ts = 4'b0010;
    repeat (4095) tick();
    chk("max count", 64'(cnt_of(1)), 64'(4095));
    tick();
    chk("max periodic done", 64'(bus.done[1]), 64'(1));
    chk("max wrap to 0", 64'(cnt_of(1)), 64'(0));

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      ss  = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < int'(NCH); i++) begin
        if ($urandom_range(0, 15) == 0) ts[i] = ~ts[i];
        if ($urandom_range(0, 9) == 0) tcv[i] = int'($urandom_range(0, 15));
        if ($urandom_range(0, 19) == 0) md[i] = ~md[i];
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
